writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the five-stage RV32I core, directly downstream of `memory_stage`. Holds the MEM/WB pipeline register; extracts and sign/zero-extends load data; selects the register-file write value; drives the register-file write port and the WB forwarding source; keeps the retired-instruction counter. Latency: one register stage; all result logic after the register is combinational.

## Interface
Parameters:
- `INSTRET_WIDTH`, default 64: width of the retired-instruction counter.

Ports (all data widths are `DATA_WIDTH` = 32 and `REG_ADDR_WIDTH` = 5 from `common/defines.svh`):
- `clk`  in  1  the only clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `valid_m_i`  in  1  the M-stage slot holds a real instruction (0 = bubble).
- `reg_write_m_i`  in  1  the instruction writes rd.
- `result_src_m_i`  in  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved.
- `funct3_m_i`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `read_data_m_i`  in  32  raw word from data memory at address {alu_result[31:2], 2'b00}.
- `alu_result_m_i`  in  32  ALU result or load address.
- `rd_addr_m_i`  in  5  destination register.
- `pc_plus_4_m_i`  in  32  link value.
- `stall_w_i`  in  1  hold the MEM/WB register.
- `flush_w_i`  in  1  load a bubble into the MEM/WB register.
- `rf_we_o`  out  1  register-file write enable.
- `rf_waddr_o`  out  5  register-file write address.
- `rf_wdata_o`  out  32  register-file write data; also the WB forwarding value.
- `instret_o`  out  `INSTRET_WIDTH`  count of retired instructions.

## Operation
- MEM/WB register fields: valid, reg_write, result_src, funct3, read_data, alu_result, rd_addr, pc_plus_4.
- Per edge, in priority order:
  - `rst_n`=0: all fields are cleared to 0.
  - `flush_w_i`=1: valid and reg_write are cleared to 0; the other fields are don't-care.
  - `stall_w_i`=1: all fields hold.
  - Otherwise: all fields load from the `_m_i` inputs.
- Load extraction from the registered read_data, using off = alu_result[1:0]:
  - LB/LBU: byte off, bits [8*off+7 : 8*off]. LB sign-extends; LBU zero-extends.
  - LH/LHU: half alu_result[1], bits [16*a1+15 : 16*a1]. LH sign-extends; LHU zero-extends. alu_result[0] is ignored.
  - LW and any other funct3: the full word. alu_result[1:0] is ignored.
  - Misalignment is not trapped.
- Result mux on the registered result_src:
  - 00 → alu_result.
  - 01 → extracted load data.
  - 10 → pc_plus_4.
  - 11 → 0.
- `rf_we_o` = valid & reg_write & (rd_addr ≠ 0).
- `rf_waddr_o` = rd_addr.
- `rf_wdata_o` = mux result. It is driven even when `rf_we_o`=0.
- Retirement:
  - An instruction retires in a cycle when the registered valid=1 and `stall_w_i`=0.
  - `instret_o` increments by 1 on that edge.
  - The counter wraps from all-ones to 0 with no flag.
  - Stalled cycles are never counted; a held instruction counts exactly once.
  - Flush on the same edge: the instruction currently in WB still retires that edge if not stalled; the bubble loaded by the flush never counts.

## Timing
- Reset values: `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0 (result_src 00, alu_result 0), `instret_o`=0.
- The cycle after reset deasserts: the outputs reflect whatever was loaded on the first non-reset edge.
- Latency: inputs sampled at edge N appear on `rf_*_o` from edge N until edge N+1. The register file writes them at edge N+1.
- `rf_*_o` are combinational from the register only; no input-to-output combinational path exists.
- A stall holds the outputs stable.
- Reset asserted mid-stall or mid-flush: reset wins and the counter clears.
- Flush and stall asserted together: flush wins, and a bubble is loaded.

## Test plan
- Reset: drive `rst_n`=0 with a valid instruction on the inputs → next cycle `rf_we_o`=0, `rf_wdata_o`=0, `instret_o`=0.
- Load extension: read_data=0x8081_F27F; alu_result low bits = 0,1,2,3 with LB → 0x7F, 0xFFFF_FFF2, 0xFFFF_FF81, 0xFFFF_FF80. LBU off=1 → 0xF2. LH a1=1 → 0xFFFF_8081. LHU a1=0 → 0xF27F. LW → 0x8081_F27F.
- Mux and rd0:
  - result_src=00, alu=0x1234 → wdata 0x1234.
  - result_src=10, pc+4=0x104 → wdata 0x104.
  - rd=0 with reg_write=1 → `rf_we_o`=0.
- Stall: a valid instruction, then stall for 3 cycles → outputs constant for 4 cycles; `instret_o` increments by exactly 1, on the edge that ends the stall.
- Flush: a valid instruction in WB, flush=1 for one edge → that instruction retires (instret +1). The next cycle has `rf_we_o`=0, and instret does not advance on the following edge. With flush and stall both high, a bubble is loaded.
- Stream: 10 back-to-back valid instructions interleaved with 3 bubbles (valid_m_i=0) → instret_o=10. A bubble never asserts `rf_we_o`.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: final stage of the five-stage RV32I core.
// Holds the MEM/WB pipeline register, extracts and extends load data,
// selects the register-file write value and counts retired instructions.
module writeback_stage #(
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_m_i,
  input  logic                     reg_write_m_i,
  input  logic [1:0]               result_src_m_i,
  input  logic [2:0]               funct3_m_i,
  input  logic [31:0]              read_data_m_i,
  input  logic [31:0]              alu_result_m_i,
  input  logic [4:0]               rd_addr_m_i,
  input  logic [31:0]              pc_plus_4_m_i,
  input  logic                     stall_w_i,
  input  logic                     flush_w_i,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic                      valid;
    logic                      regWrite;
    logic [1:0]                resultSrc;
    logic [2:0]                funct3;
    logic [DATA_WIDTH-1:0]     readData;
    logic [DATA_WIDTH-1:0]     aluResult;
    logic [REG_ADDR_WIDTH-1:0] rdAddr;
    logic [DATA_WIDTH-1:0]     pcPlus4;
  } memWb_t;

  memWb_t                   memWb_q, memWb_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
  logic [7:0]               loadByte;
  logic [15:0]              loadHalf;
  logic [DATA_WIDTH-1:0]    loadData;
  logic [DATA_WIDTH-1:0]    resultData;

  // Next MEM/WB contents: flush injects a bubble (beating stall), stall holds, else load from M.
  always_comb begin
    memWb_d = memWb_q;
    if (flush_w_i) begin
      memWb_d.valid    = 1'b0;
      memWb_d.regWrite = 1'b0;
    end else if (!stall_w_i) begin
      memWb_d.valid     = valid_m_i;
      memWb_d.regWrite  = reg_write_m_i;
      memWb_d.resultSrc = result_src_m_i;
      memWb_d.funct3    = funct3_m_i;
      memWb_d.readData  = read_data_m_i;
      memWb_d.aluResult = alu_result_m_i;
      memWb_d.rdAddr    = rd_addr_m_i;
      memWb_d.pcPlus4   = pc_plus_4_m_i;
    end
  end

  // The instruction sitting in WB retires on any edge where it is not stalled, flush or not.
  always_comb begin
    instret_d = instret_q;
    if (memWb_q.valid && !stall_w_i) begin
      instret_d = instret_q + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Pipeline register and retirement counter, synchronously cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memWb_q   <= '0;
      instret_q <= '0;
    end else begin
      memWb_q   <= memWb_d;
      instret_q <= instret_d;
    end
  end

  // Pick the addressed byte/half from the aligned word; misaligned accesses are not trapped.
  always_comb begin
    loadByte = memWb_q.readData[7:0];
    case (memWb_q.aluResult[1:0])
      2'd0:    loadByte = memWb_q.readData[7:0];
      2'd1:    loadByte = memWb_q.readData[15:8];
      2'd2:    loadByte = memWb_q.readData[23:16];
      default: loadByte = memWb_q.readData[31:24];
    endcase
    loadHalf = memWb_q.aluResult[1] ? memWb_q.readData[31:16] : memWb_q.readData[15:0];
  end

  // Sign- or zero-extend according to the load type; unknown types return the full word.
  always_comb begin
    loadData = memWb_q.readData;
    case (memWb_q.funct3)
      F3_LB:   loadData = {{24{loadByte[7]}}, loadByte};
      F3_LH:   loadData = {{16{loadHalf[15]}}, loadHalf};
      F3_LBU:  loadData = {24'h000000, loadByte};
      F3_LHU:  loadData = {16'h0000, loadHalf};
      default: loadData = memWb_q.readData;
    endcase
  end

  // Write-back value select; the reserved encoding yields zero.
  always_comb begin
    resultData = '0;
    case (memWb_q.resultSrc)
      SRC_ALU:  resultData = memWb_q.aluResult;
      SRC_LOAD: resultData = loadData;
      SRC_PC4:  resultData = memWb_q.pcPlus4;
      default:  resultData = '0;
    endcase
  end

  assign rf_we_o    = memWb_q.valid & memWb_q.regWrite & (memWb_q.rdAddr != '0);
  assign rf_waddr_o = memWb_q.rdAddr;
  assign rf_wdata_o = resultData;
  assign instret_o  = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scoreboard bench for writeback_stage.
// Stimulus pushes hand-computed expectations; a monitor pops one per clock edge.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_m_i;
  logic        reg_write_m_i;
  logic [1:0]  result_src_m_i;
  logic [2:0]  funct3_m_i;
  logic [31:0] read_data_m_i;
  logic [31:0] alu_result_m_i;
  logic [4:0]  rd_addr_m_i;
  logic [31:0] pc_plus_4_m_i;
  logic        stall_w_i;
  logic        flush_w_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [63:0] instret_o;

  typedef struct {
    logic        we;
    logic        dataCare;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [63:0] instret;
    string       name;
  } exp_t;

  exp_t        expQ[$];
  exp_t        monE;
  int          checkCount;
  int          passCount;
  logic        modelValid;
  logic [63:0] modelInstret;
  logic [63:0] streamBase;

  localparam logic [31:0] LOAD_WORD = 32'h8081_F27F;

  writeback_stage #(.INSTRET_WIDTH(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_m_i      (valid_m_i),
    .reg_write_m_i  (reg_write_m_i),
    .result_src_m_i (result_src_m_i),
    .funct3_m_i     (funct3_m_i),
    .read_data_m_i  (read_data_m_i),
    .alu_result_m_i (alu_result_m_i),
    .rd_addr_m_i    (rd_addr_m_i),
    .pc_plus_4_m_i  (pc_plus_4_m_i),
    .stall_w_i      (stall_w_i),
    .flush_w_i      (flush_w_i),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .instret_o      (instret_o)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at the falling edge and queue what the outputs must show after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic vld, input logic rw,
                               input logic [1:0] src, input logic [2:0] f3,
                               input logic [31:0] rdata, input logic [31:0] alu,
                               input logic [4:0] rd, input logic [31:0] pc4,
                               input logic stall, input logic flush,
                               input logic expWe, input logic care,
                               input logic [4:0] expWaddr, input logic [31:0] expWdata,
                               input string name);
    exp_t e;
    @(negedge clk);
    rst_n          = ~rst;
    valid_m_i      = vld;
    reg_write_m_i  = rw;
    result_src_m_i = src;
    funct3_m_i     = f3;
    read_data_m_i  = rdata;
    alu_result_m_i = alu;
    rd_addr_m_i    = rd;
    pc_plus_4_m_i  = pc4;
    stall_w_i      = stall;
    flush_w_i      = flush;
    if (rst) begin
      modelInstret = '0;
      modelValid   = 1'b0;
    end else begin
      if (modelValid && !stall) modelInstret = modelInstret + 64'd1;
      if (flush) modelValid = 1'b0;
      else if (!stall) modelValid = vld;
    end
    e.we       = expWe;
    e.dataCare = care;
    e.waddr    = expWaddr;
    e.wdata    = expWdata;
    e.instret  = modelInstret;
    e.name     = name;
    expQ.push_back(e);
  endtask

  // Shorthand for a valid load into x5 from LOAD_WORD.
  task automatic loadVec(input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] expData, input string name);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, f3, LOAD_WORD, alu, 5'd5, 32'h0,
                  1'b0, 1'b0, 1'b1, 1'b1, 5'd5, expData, name);
  endtask

  // Compare the DUT outputs against one scoreboard entry.
  task automatic checkOutput(input exp_t e);
    checkCount++;
    if (rf_we_o === e.we) passCount++;
    else $display("[TB] FAIL %s rf_we_o: got %0b expected %0b", e.name, rf_we_o, e.we);
    checkCount++;
    if (instret_o === e.instret) passCount++;
    else $display("[TB] FAIL %s instret_o: got %0d expected %0d", e.name, instret_o, e.instret);
    if (e.dataCare) begin
      checkCount++;
      if (rf_waddr_o === e.waddr) passCount++;
      else $display("[TB] FAIL %s rf_waddr_o: got %0d expected %0d", e.name, rf_waddr_o, e.waddr);
      checkCount++;
      if (rf_wdata_o === e.wdata) passCount++;
      else $display("[TB] FAIL %s rf_wdata_o: got %h expected %h", e.name, rf_wdata_o, e.wdata);
    end
  endtask

  // Monitor: one rising edge consumes one expectation, sampled just after the edge.
  always begin
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput(monE);
    end
  end

  // Directed sequence.
  initial begin
    checkCount     = 0;
    passCount      = 0;
    modelValid     = 1'b0;
    modelInstret   = '0;
    streamBase     = '0;
    rst_n          = 1'b0;
    valid_m_i      = 1'b1;
    reg_write_m_i  = 1'b1;
    result_src_m_i = 2'b00;
    funct3_m_i     = 3'b010;
    read_data_m_i  = 32'h0;
    alu_result_m_i = 32'h1234;
    rd_addr_m_i    = 5'd3;
    pc_plus_4_m_i  = 32'h0;
    stall_w_i      = 1'b0;
    flush_w_i      = 1'b0;

    // Reset with a live instruction on the inputs
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'b010, 32'h0, 32'h1234, 5'd3, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, "reset0");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 32'h0, 32'h1234, 5'd3, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, "reset1");

    // Load extraction
    loadVec(3'b000, 32'h100, 32'h0000_007F, "lb_off0");
    loadVec(3'b000, 32'h101, 32'hFFFF_FFF2, "lb_off1");
    loadVec(3'b000, 32'h102, 32'hFFFF_FF81, "lb_off2");
    loadVec(3'b000, 32'h103, 32'hFFFF_FF80, "lb_off3");
    loadVec(3'b100, 32'h101, 32'h0000_00F2, "lbu_off1");
    loadVec(3'b100, 32'h103, 32'h0000_0080, "lbu_off3");
    loadVec(3'b001, 32'h102, 32'hFFFF_8081, "lh_a1");
    loadVec(3'b001, 32'h103, 32'hFFFF_8081, "lh_a1_odd");
    loadVec(3'b101, 32'h100, 32'h0000_F27F, "lhu_a0");
    loadVec(3'b101, 32'h101, 32'h0000_F27F, "lhu_a0_odd");
    loadVec(3'b010, 32'h103, 32'h8081_F27F, "lw");
    loadVec(3'b111, 32'h101, 32'h8081_F27F, "f3_other");

    // Result mux and x0 handling
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, LOAD_WORD, 32'h1234, 5'd7, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1234, "mux_alu");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 3'b000, LOAD_WORD, 32'h55, 5'd1, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h104, "mux_pc4");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 3'b000, LOAD_WORD, 32'h55, 5'd2, 32'h104, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0, "mux_rsvd");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, LOAD_WORD, 32'h99, 5'd0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h99, "rd0");
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, LOAD_WORD, 32'h98, 5'd4, 32'h104, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h98, "no_rw");

    // Stall: one instruction held for three extra edges
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 32'h0, 32'hABC, 5'd9, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 32'hABC, "stall_load");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 3'b000, 32'h0, 32'hDEAD, 5'd1, 32'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'hABC, "stall_hold");
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h0, 32'h77, 5'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h77, "stall_end");

    // Flush: the instruction in WB retires, the injected bubble does not
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 32'h0, 32'h10, 5'd10, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd10, 32'h10, "flush_load");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 32'h0, 32'h20, 5'd11, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "flush_edge");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h21, 5'd12, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h21, "flush_after");

    // Flush and stall together: bubble loaded, stalled instruction not counted
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 32'h0, 32'h30, 5'd12, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 32'h30, "fs_load");
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 32'h0, 32'h31, 5'd13, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, "fs_edge");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h32, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 32'h32, "fs_after");

    // Reset asserted during a stall clears everything
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 32'h0, 32'h40, 5'd15, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd15, 32'h40, "rs_load");
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 3'b000, 32'h0, 32'h41, 5'd16, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, "rs_edge");
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h42, 5'd17, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd17, 32'h42, "rs_after");

    // Stream: 10 valid instructions with bubbles at slots 3, 7 and 11
    streamBase = modelInstret;
    for (int i = 0; i < 13; i++) begin
      if (i == 3 || i == 7 || i == 11) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 3'b000, 32'h0, 32'h1000 + i, 5'(i + 1), 32'h0,
                      1'b0, 1'b0, 1'b0, 1'b1, 5'(i + 1), 32'h1000 + i, "stream_bubble");
      end else begin
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 32'h0, 32'h1000 + i, 5'(i + 1), 32'h0,
                      1'b0, 1'b0, 1'b1, 1'b1, 5'(i + 1), 32'h1000 + i, "stream_valid");
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, "stream_tail");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end

    // The reset-to-stream window ran exactly 10 real instructions
    checkCount++;
    if (instret_o === streamBase + 64'd10) passCount++;
    else $display("[TB] FAIL stream_total instret_o: got %0d expected %0d", instret_o, streamBase + 64'd10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
